// File: rtl/time_digits_to_seconds.sv
// Packed-BCD mm:ss / hh:mm:ss entry to binary seconds, one Horner step per cycle.
// Result saturates at 2^OUT_W-1 and is held until the downstream side takes it.
module time_digits_to_seconds #(
    parameter int  NUM_FIELDS = 2,
    parameter int  OUT_W      = 19,
    localparam int NUM_DIGITS = 2 * NUM_FIELDS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        seconds_out,
    output logic                    err,
    output logic                    ovf
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int ACC_W = OUT_W + 4;
    localparam logic [ACC_W-1:0] SAT = {4'b0000, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                  state, state_nxt;
    logic [4*NUM_DIGITS-1:0] dig_q;
    logic [ACC_W-1:0]        acc;
    logic [IDX_W-1:0]        idx;
    logic                    err_q, ovf_q;

    logic                    illegal;
    logic [3:0]              cur;
    logic [ACC_W-1:0]        step;
    logic                    accept;

    assign accept = in_valid && (state == IDLE);

    // Units digits and the top digit go to 9; the other tens digits stop at 5.
    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i % 2 == 0) || (i == NUM_DIGITS - 1)) begin
                if (digits[4*i +: 4] > 4'd9) illegal = 1'b1;
            end else begin
                if (digits[4*i +: 4] > 4'd5) illegal = 1'b1;
            end
        end
    end

    // acc never exceeds SAT, so acc*10+9 always fits in the 4 spare bits.
    always_comb begin
        cur  = dig_q[4*idx +: 4];
        step = (idx[0] ? acc * ACC_W'(6) : acc * ACC_W'(10)) + ACC_W'(cur);
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = illegal ? DONE : CONV;
            CONV:    if (idx == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig_q <= '0;
            acc   <= '0;
            idx   <= '0;
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dig_q <= digits;
                        err_q <= illegal;
                        ovf_q <= 1'b0;
                        acc   <= illegal ? '0 : ACC_W'(digits[4*NUM_DIGITS-1 -: 4]);
                        idx   <= IDX_W'(NUM_DIGITS - 2);
                    end
                end
                CONV: begin
                    if (ovf_q || (step > SAT)) begin
                        acc   <= SAT;
                        ovf_q <= 1'b1;
                    end else begin
                        acc <= step;
                    end
                    if (idx != '0) idx <= idx - IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign seconds_out = acc[OUT_W-1:0];
    assign err         = err_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_time_digits_to_seconds.sv
// Drives three converter configurations (mm:ss, hh:mm:ss, hh:mm:ss with 12-bit output)
// against a field-arithmetic reference model, with directed corner cases and random entries.
module tb_time_digits_to_seconds;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  in_valid, in_ready, out_valid, out_ready, err_o, ovf_o;
    logic [23:0] dig [3];
    logic [18:0] sec0, sec1;
    logic [11:0] sec2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    time_digits_to_seconds #(.NUM_FIELDS(2), .OUT_W(19)) dut_mmss (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .digits(dig[0][15:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .seconds_out(sec0), .err(err_o[0]), .ovf(ovf_o[0]));

    time_digits_to_seconds #(.NUM_FIELDS(3), .OUT_W(19)) dut_hhmmss (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .digits(dig[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .seconds_out(sec1), .err(err_o[1]), .ovf(ovf_o[1]));

    time_digits_to_seconds #(.NUM_FIELDS(3), .OUT_W(12)) dut_narrow (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .digits(dig[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .seconds_out(sec2), .err(err_o[2]), .ovf(ovf_o[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sec_of(input int k);
        case (k)
            0:       return 32'(sec0);
            1:       return 32'(sec1);
            default: return 32'(sec2);
        endcase
    endfunction

    function automatic logic [23:0] pack(input int hh, input int mm, input int ss);
        logic [23:0] d;
        d[23:20] = 4'(hh / 10); d[19:16] = 4'(hh % 10);
        d[15:12] = 4'(mm / 10); d[11:8]  = 4'(mm % 10);
        d[7:4]   = 4'(ss / 10); d[3:0]   = 4'(ss % 10);
        return d;
    endfunction

    // Reference: legality per digit, then total = hh*3600 + mm*60 + ss, saturated.
    task automatic model(input int k, input logic [23:0] d, output int unsigned s,
                         output logic e, output logic o, output int lat);
        int nf  = (k == 0) ? 2 : 3;
        int w   = (k == 2) ? 12 : 19;
        int nd  = 2 * nf;
        longint unsigned mx = (64'd1 << w) - 1;
        longint unsigned total;
        int hh, mm, ss;
        e = 1'b0;
        for (int i = 0; i < nd; i++) begin
            int lim = ((i % 2 == 0) || (i == nd - 1)) ? 9 : 5;
            if (int'(d[4*i +: 4]) > lim) e = 1'b1;
        end
        ss = int'(d[7:4]) * 10 + int'(d[3:0]);
        mm = int'(d[15:12]) * 10 + int'(d[11:8]);
        hh = (nf == 3) ? int'(d[23:20]) * 10 + int'(d[19:16]) : 0;
        total = longint'(hh) * 3600 + longint'(mm) * 60 + longint'(ss);
        if (e) begin
            s = 0; o = 1'b0; lat = 1;
        end else begin
            o   = (total > mx);
            s   = o ? int'(mx) : int'(total);
            lat = nd;
        end
    endtask

    task automatic run(input int k, input logic [23:0] d, input int hold, input string tag);
        int          n = 0;
        int          lat;
        int unsigned es;
        logic        ee, eo;
        int          el;
        while (!in_ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready[k]), 1);
        dig[k]       = d;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        dig[k]      = 24'($urandom);
        lat = 1;
        while (!out_valid[k] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        model(k, d, es, ee, eo, el);
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " seconds"}, sec_of(k), es);
        check({tag, " err"}, 32'(err_o[k]), 32'(ee));
        check({tag, " ovf"}, 32'(ovf_o[k]), 32'(eo));
        // A new entry offered while the result is held must be ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid[k] = 1'b1;
            dig[k]      = 24'($urandom);
            @(negedge clk);
        end
        if (hold > 0) begin
            check({tag, " hold valid"}, 32'(out_valid[k]), 1);
            check({tag, " hold seconds"}, sec_of(k), es);
            check({tag, " hold in_ready"}, 32'(in_ready[k]), 0);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge clk);
        check({tag, " back to idle"}, 32'(in_ready[k]), 1);
        check({tag, " valid dropped"}, 32'(out_valid[k]), 0);
        out_ready[k] = 1'b0;
    endtask

    task automatic check_reset_outputs(input int k, input string tag);
        check({tag, " in_ready"}, 32'(in_ready[k]), 1);
        check({tag, " out_valid"}, 32'(out_valid[k]), 0);
        check({tag, " seconds"}, sec_of(k), 0);
        check({tag, " err"}, 32'(err_o[k]), 0);
        check({tag, " ovf"}, 32'(ovf_o[k]), 0);
    endtask

    function automatic logic [23:0] rand_entry();
        logic [23:0] d;
        for (int i = 0; i < 6; i++) begin
            int lim = (i % 2 == 0) ? 9 : 5;
            if ($urandom_range(0, 9) < 8) d[4*i +: 4] = 4'($urandom_range(0, lim));
            else                          d[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) dig[k] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset_outputs(k, "por");
        reset = 1'b1;
        @(negedge clk);

        run(0, pack(0, 59, 59), 0, "59:59");
        run(0, pack(0, 99, 59), 0, "99:59");
        run(0, pack(0, 0, 60), 0, "00:60");
        run(1, pack(12, 34, 56), 0, "12:34:56");
        run(1, pack(99, 59, 59), 0, "99:59:59");
        run(2, pack(1, 8, 16), 0, "narrow 01:08:16");
        run(2, pack(1, 8, 15), 0, "narrow 01:08:15");
        run(0, pack(0, 59, 59), 10, "held 59:59");
        run(0, pack(0, 12, 34), 0, "after hold 12:34");

        // Reset during the second conversion cycle.
        dig[1]      = pack(12, 34, 56);
        in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs(1, "mid-conv reset");
        @(negedge clk);
        check_reset_outputs(1, "reset held");
        reset = 1'b1;
        @(negedge clk);
        run(1, pack(0, 0, 1), 0, "post-reset 00:01");

        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 3; k++) begin
                run(k, rand_entry(), int'($urandom_range(0, 2)), $sformatf("rand k%0d #%0d", k, it));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
